// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM state encoding and the iteration count.
package mdu_pkg;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      MDU_MULTU = 2'b00,
      MDU_MULT  = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op == MDU_DIVU || op == MDU_DIV;
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op == MDU_MULT || op == MDU_DIV;
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Iterative multiply/divide datapath: 64-bit shift register, one
// shared 33-bit add/sub, abs on load and sign fix-up on the result.
// Ports: clk, rst (sync, active-high); load_i latches operands for
// op_i; step_i performs one iteration; hi_o/lo_o give the signed-
// corrected result, valid in the FIX cycle.
// Optional macro MDU_FAST_MULT_EN: product computed with '*' on load.
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   localparam int W = 2 * XLEN;

   logic [W-1:0]    acc_q, acc_d;
   logic [XLEN-1:0] m_q, m_d;
   logic            div_q, div_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;

   logic            sa, sb, b_zero;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   add_x, add_y, sum;
   logic            ge;
   logic [W-1:0]    prod;
   logic [XLEN-1:0] quo, rem;

   assign sa     = op_is_signed(op_i) & a_i[XLEN-1];
   assign sb     = op_is_signed(op_i) & b_i[XLEN-1];
   assign abs_a  = sa ? -a_i : a_i;
   assign abs_b  = sb ? -b_i : b_i;
   assign b_zero = (b_i == '0);

   // Multiply adds the multiplicand to the upper half; divide
   // subtracts the divisor from the 33-bit shifted remainder.
   assign add_x = div_q ? acc_q[W-1:XLEN-1]
                        : {1'b0, acc_q[W-1:XLEN]};
   assign add_y = div_q ? ~{1'b0, m_q} : {1'b0, m_m_fix(m_q)};
   assign sum   = add_x + add_y + (XLEN+1)'(div_q);

   // A set top bit means the remainder already exceeds any divisor.
   assign ge = acc_q[W-1] | ~sum[XLEN];

   function automatic logic [XLEN-1:0] m_m_fix(input logic [XLEN-1:0] v);
      return v;
   endfunction

   always_comb begin
      acc_d  = acc_q;
      m_d    = m_q;
      div_d  = div_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (load_i) begin
         div_d = op_is_div(op_i);
         if (op_is_div(op_i)) begin
            m_d    = abs_b;
            acc_d  = {{XLEN{1'b0}}, abs_a};
            // Divide by zero keeps an all-ones quotient.
            negq_d = (sa ^ sb) & ~b_zero;
            negr_d = sa;
         end else begin
            m_d    = abs_a;
            acc_d  = {{XLEN{1'b0}}, abs_b};
            negq_d = sa ^ sb;
            negr_d = 1'b0;
`ifdef MDU_FAST_MULT_EN
            acc_d  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif
         end
      end else if (step_i) begin
         if (div_q) begin
            acc_d = ge ? {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {acc_q[W-2:0], 1'b0};
         end else begin
            acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[W-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         m_q    <= '0;
         div_q  <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         m_q    <= m_d;
         div_q  <= div_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

   assign prod = negq_q ? -acc_q : acc_q;
   assign quo  = acc_q[XLEN-1:0];
   assign rem  = acc_q[W-1:XLEN];

   assign hi_o = div_q ? (negr_q ? -rem : rem) : prod[W-1:XLEN];
   assign lo_o = div_q ? (negq_q ? -quo : quo) : prod[XLEN-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports: clk, rst (sync, active-high); start/op/src_a/src_b issue an
// op; cancel aborts; mthi_we/mtlo_we/wdata write HI/LO; busy is
// state != IDLE; done pulses with new HI/LO; hi/lo feed the ALU.
// Optional macro MDU_FAST_MULT_EN: multiply goes IDLE -> FIX.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            cancel,
   input  logic            mthi_we,
   input  logic            mtlo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(MDU_ITER);

   mdu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            done_q, done_d;
   logic            load, step;
   logic [XLEN-1:0] res_hi, res_lo;

   mdu_datapath #(
      .XLEN (XLEN)
   ) u_dp (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .step_i (step),
      .op_i   (op),
      .a_i    (src_a),
      .b_i    (src_b),
      .hi_o   (res_hi),
      .lo_o   (res_lo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      if (mthi_we) hi_d = wdata;
      if (mtlo_we) lo_d = wdata;
      unique case (state_q)
         IDLE: begin
            if (start && !cancel) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = CALC;
`ifdef MDU_FAST_MULT_EN
               if (!op_is_div(op)) state_d = FIX;
`endif
            end
         end
         CALC: begin
            if (cancel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(MDU_ITER - 1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            // Writeback wins over a same-cycle MTHI/MTLO.
            if (!cancel) begin
               hi_d   = res_hi;
               lo_d   = res_lo;
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits beside the ALU in the execute stage. The unit executes MULT, MULTU, DIV and DIVU iteratively, writes HI/LO, and supplies HI/LO to the ALU as its MFHI/MFLO operands. The pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32, operand width. Only 32 is supported and verified.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  request an operation; accepted only in IDLE
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV (equals ALUctr[1:0] of the ALU mult/div codes)
- `src_a`  in  32  multiplicand or dividend (rs)
- `src_b`  in  32  multiplier or divisor (rt)
- `cancel`  in  1  exception flush; aborts any operation in flight
- `mthi_we`  in  1  write `wdata` to HI
- `mtlo_we`  in  1  write `wdata` to LO
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse; new HI/LO are visible in this cycle
- `hi`  out  32  HI register (drives the ALU aluA operand for MFHI)
- `lo`  out  32  LO register (drives the ALU aluB operand for MFLO)

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, iteration counter 0.
- FSM states and transitions:
  - IDLE → CALC on `start` & !`cancel`.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE, writing HI/LO and asserting `done` on the next cycle.
  - Any state → IDLE on `cancel`.
- On accept, the unit latches the magnitudes of `src_a`/`src_b`. For MULT/DIV it takes absolute values; for MULTU/DIVU it uses the raw values. It also latches the result sign flags.
- Multiply: radix-2 shift-add into a 64-bit product. In FIX, the product is negated if sign(a)^sign(b) (signed ops only). HI = product[63:32], LO = product[31:0].
- Divide: restoring radix-2 with a 64-bit remainder/quotient shift register, one bit per cycle.
  - In FIX, the quotient is negated if sign(a)^sign(b) and the remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (both ops): LO=0xFFFFFFFF, HI=dividend. Fixed behaviour, not an exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic; no special case.
- `start` while busy is ignored; operands are not re-latched.
- MTHI/MTLO:
  - In IDLE, the write applies at the next edge.
  - In CALC the write applies, but a later FIX overwrites it.
  - In FIX, the FIX writeback has priority.
- `cancel`: next state IDLE, HI/LO unchanged, no `done`. `cancel` & `start` together means start is not accepted.
- `rst` mid-operation: full reset; no `done`.

## Timing
- `start` sampled at edge T (cycle T):
  - `busy`=1 in cycles T+1..T+33 (32 CALC + 1 FIX).
  - `done`=1 and new HI/LO in cycle T+34.
  - Latency is 34 cycles.
- State is IDLE in the `done` cycle, so back-to-back `start` is accepted in T+34.
- `busy` is decoded from registered state (no combinational path from inputs). `done` is registered.

## Configuration
- `MDU_FAST_MULT_EN` defined: MULT/MULTU compute the 64-bit product with a single-cycle `*` in CALC's place. The FSM goes IDLE → FIX directly: `busy` in T+1 only, `done` in T+2. Divide is unchanged.
- Undefined: multiply is iterative as above (34-cycle latency), with no hardware multiplier inferred.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_MULTU`…`MDU_DIV`), FSM state enum (IDLE/CALC/FIX), `MDU_ITER`=32.
- Sub-module `mdu_datapath`: 64-bit shift register, 33-bit adder/subtractor shared by multiply and divide, abs/negate logic.
- Top level `mul_div_unit`: FSM, iteration counter, and HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF at T → `done` at T+34, HI=0xFFFFFFFE, LO=0x00000001, `busy` T+1..T+33.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat with `MDU_FAST_MULT_EN`: `done` at T+2, same values.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=0x00000064; DIVU 100/7 → LO=14, HI=2.
- Start at T with HI=LO=0x11111111, `cancel` at T+10 → no `done`, `busy`=0 at T+11, HI/LO unchanged; `start` at T+11 accepted.
- `start` again at T+5 while busy → ignored (result uses the T operands).
- `mthi_we` with 0x1234 in IDLE → HI=0x1234 next cycle.
- `rst` at T+20 → HI=LO=0, `busy`=0, no `done`.
